// File: rtl/fifo_push_arb_pkg.sv
// fifo_push_arb_pkg
//   Shared types and helpers for the FIFO push-port arbiter.
//   - arb_state_e : arbiter FSM state (idle / burst locked to one owner)
//   - rr_next     : wrapping increment of a round-robin index modulo num
package fifo_push_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    // Next round-robin index after idx, wrapping back to 0 at num.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num);
        return (idx + 1 >= num) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_push_arb_rr_find_first.sv
// rr_find_first
//   Combinational round-robin leading-one search. Starting at start_i and
//   moving upward with wrap-around modulo N, returns the first set bit of
//   req_i. When nothing is set, idx_o = start_i and found_o = 0.
//   Ports:
//     req_i   [N-1:0] request vector
//     start_i [W-1:0] highest-priority index (must be < N)
//     idx_o   [W-1:0] index of the first request found
//     found_o         at least one request set
module rr_find_first #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] start_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    // cand[gi] is the requester index examined at search offset gi.
    logic [W-1:0] cand [N];
    logic [N-1:0] cand_valid;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            logic [W:0] sum;
            // start_i < N, so the sum is below 2N and one subtraction wraps it.
            assign sum            = {1'b0, start_i} + (W+1)'(gi);
            assign cand[gi]       = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);
            assign cand_valid[gi] = req_i[cand[gi]];
        end
    endgenerate

    // Scan from the far end so the smallest offset is written last and wins.
    always_comb begin
        idx_o   = start_i;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand_valid[i]) begin
                idx_o   = cand[i];
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_push_arb.sv
// fifo_push_arb
//   Burst-granular round-robin arbiter sharing one FIFO push port among
//   NUM_REQ producers. A winner holds the port until it flags its last beat
//   or has pushed MAX_BURST beats, so every burst lands contiguously.
//   Optional feature macro: FIFO_PUSH_ARB_THROTTLE_EN -- when defined, no new
//   burst starts while fifo_alm_full_i is high (running bursts continue).
//   Ports:
//     clk_i, rst_i          clock, synchronous active-high reset
//     flush_i               abort current burst, suppress this cycle's beat
//     req_valid_i/_last_i   per-requester beat valid / last-beat marker
//     req_data_i            packed beats, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//     req_ready_o           one-hot beat-accepted strobe
//     fifo_full_i           FIFO full flag (blocks beats)
//     fifo_alm_full_i       FIFO almost-full flag (throttle build only)
//     fifo_push_o/_data_o   push strobe and data to the FIFO
//     grant_idx_o           current owner, or the just-selected winner in idle
//     busy_o                high while a burst holds the port
module fifo_push_arb
    import fifo_push_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4,
    parameter int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    input  logic                          fifo_alm_full_i,
    output logic                          fifo_push_o,
    output logic [DATA_WIDTH-1:0]         fifo_data_o,
    output logic [IDX_W-1:0]              grant_idx_o,
    output logic                          busy_o
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e       state_q,    state_d;
    logic [IDX_W-1:0] rr_ptr_q,   rr_ptr_d;
    logic [IDX_W-1:0] owner_q,    owner_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic [IDX_W-1:0]      ff_idx;
    logic                  ff_found;
    logic [IDX_W-1:0]      winner;
    logic                  allow;
    logic                  beat;
    logic [CNT_W-1:0]      cnt_after;
    logic                  burst_end;
    logic [DATA_WIDTH-1:0] data_slice [NUM_REQ];

    rr_find_first #(
        .N (NUM_REQ),
        .W (IDX_W)
    ) u_find (
        .req_i   (req_valid_i),
        .start_i (rr_ptr_q),
        .idx_o   (ff_idx),
        .found_o (ff_found)
    );

    // With no valid requester in idle the search returns rr_ptr itself.
    assign winner = (state_q == ARB_BURST) ? owner_q : ff_idx;

`ifdef FIFO_PUSH_ARB_THROTTLE_EN
    // Only the start of a burst is gated; a running burst runs until full.
    assign allow = (state_q == ARB_BURST) || !fifo_alm_full_i;
`else
    logic alm_full_unused;
    assign alm_full_unused = fifo_alm_full_i;
    assign allow           = 1'b1;
`endif

    assign beat = !rst_i && req_valid_i[winner] && !fifo_full_i && !flush_i && allow;

    // Beat count including the current beat; first beat of a burst is 1.
    assign cnt_after = (state_q == ARB_BURST) ? beat_cnt_q + 1'b1 : CNT_W'(1);
    assign burst_end = beat && (req_last_i[winner] || (cnt_after == CNT_W'(MAX_BURST)));

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
            assign data_slice[gi]  = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req_ready_o[gi] = beat && (winner == IDX_W'(gi));
        end
    endgenerate

    assign fifo_push_o = beat;
    assign fifo_data_o = data_slice[winner];
    assign grant_idx_o = winner;
    assign busy_o      = (state_q == ARB_BURST);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        if (flush_i) begin
            state_d    = ARB_IDLE;
            beat_cnt_d = '0;
            if (state_q == ARB_BURST) begin
                rr_ptr_d = IDX_W'(rr_next(32'(owner_q), NUM_REQ));
            end
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (beat) begin
                        if (burst_end) begin
                            rr_ptr_d = IDX_W'(rr_next(32'(winner), NUM_REQ));
                        end else begin
                            state_d    = ARB_BURST;
                            owner_d    = winner;
                            beat_cnt_d = CNT_W'(1);
                        end
                    end
                end
                ARB_BURST: begin
                    if (beat) begin
                        if (burst_end) begin
                            state_d    = ARB_IDLE;
                            beat_cnt_d = '0;
                            rr_ptr_d   = IDX_W'(rr_next(32'(owner_q), NUM_REQ));
                        end else begin
                            beat_cnt_d = cnt_after;
                        end
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_push_arb.sv
// tb_fifo_push_arb
//   Scenario tasks plus a randomized run, each compared cycle by cycle against
//   a burst-level reference model (owner / round-robin pointer / beats so far).
module tb_fifo_push_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 4;
    localparam int IW = 2;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            flush_i;
    logic [N-1:0]    req_valid_i;
    logic [N*DW-1:0] req_data_i;
    logic [N-1:0]    req_last_i;
    logic [N-1:0]    req_ready_o;
    logic            fifo_full_i;
    logic            fifo_alm_full_i;
    logic            fifo_push_o;
    logic [DW-1:0]   fifo_data_o;
    logic [IW-1:0]   grant_idx_o;
    logic            busy_o;

    always #5 clk_i = ~clk_i;

    fifo_push_arb #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .req_valid_i     (req_valid_i),
        .req_data_i      (req_data_i),
        .req_last_i      (req_last_i),
        .req_ready_o     (req_ready_o),
        .fifo_full_i     (fifo_full_i),
        .fifo_alm_full_i (fifo_alm_full_i),
        .fifo_push_o     (fifo_push_o),
        .fifo_data_o     (fifo_data_o),
        .grant_idx_o     (grant_idx_o),
        .busy_o          (busy_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: m_owner < 0 means no burst holds the port.
    int m_owner = -1;
    int m_rr    = 0;
    int m_cnt   = 0;

    int            exp_win;
    logic          exp_push;
    logic [N-1:0]  exp_ready;
    logic [DW-1:0] exp_data;
    logic          exp_busy;

    task automatic model_eval();
        logic allow;
        exp_win = m_rr;
        if (m_owner >= 0) begin
            exp_win = m_owner;
        end else begin
            for (int off = N - 1; off >= 0; off--) begin
                if (req_valid_i[(m_rr + off) % N]) exp_win = (m_rr + off) % N;
            end
        end
        allow = 1'b1;
`ifdef FIFO_PUSH_ARB_THROTTLE_EN
        allow = (m_owner >= 0) || !fifo_alm_full_i;
`endif
        exp_push  = !rst_i && req_valid_i[exp_win] && !fifo_full_i && !flush_i && allow;
        exp_ready = exp_push ? N'(1 << exp_win) : '0;
        exp_data  = req_data_i[exp_win*DW +: DW];
        exp_busy  = (m_owner >= 0);
    endtask

    task automatic model_advance();
        if (rst_i) begin
            m_owner = -1; m_rr = 0; m_cnt = 0;
        end else if (flush_i) begin
            if (m_owner >= 0) m_rr = (m_owner + 1) % N;
            m_owner = -1; m_cnt = 0;
        end else if (exp_push) begin
            m_cnt = m_cnt + 1;
            if (req_last_i[exp_win] || m_cnt == MB) begin
                m_rr = (exp_win + 1) % N; m_owner = -1; m_cnt = 0;
            end else begin
                m_owner = exp_win;
            end
        end
    endtask

    task automatic tick();
        model_advance();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        rst_i = 1'b0; flush_i = 1'b0; fifo_full_i = 1'b0; fifo_alm_full_i = 1'b0;
        req_valid_i = '0; req_last_i = '0; req_data_i = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_i = 1'b1;
        #1 model_eval();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b1;
        req_valid_i = 4'hF;
        #1 model_eval();
        if (fifo_push_o !== 1'b0) begin n_fail++; $display("FAIL reset_push got=%b want=0", fifo_push_o); end
        n_checks++;
        if (req_ready_o !== 4'b0) begin n_fail++; $display("FAIL reset_ready got=%b want=0000", req_ready_o); end
        n_checks++;
        tick();
        req_valid_i = '0;
        #1 model_eval();
        if (grant_idx_o !== 2'd0) begin n_fail++; $display("FAIL reset_grant got=%0d want=0", grant_idx_o); end
        n_checks++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy_o); end
        n_checks++;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_single();
        int pushes = 0;
        int busy_cycles = 0;
        apply_reset();
        for (int b = 0; b < 3; b++) begin
            req_valid_i = 4'b0100;
            req_last_i  = (b == 2) ? 4'b0100 : 4'b0000;
            req_data_i  = {$urandom, $urandom, $urandom, $urandom};
            #1 model_eval();
            if (fifo_push_o !== exp_push) begin n_fail++; $display("FAIL single_push beat=%0d got=%b want=%b", b, fifo_push_o, exp_push); end
            n_checks++;
            if (fifo_data_o !== exp_data) begin n_fail++; $display("FAIL single_data beat=%0d got=%h want=%h", b, fifo_data_o, exp_data); end
            n_checks++;
            if (fifo_push_o === 1'b1) pushes++;
            if (busy_o === 1'b1) busy_cycles++;
            tick();
        end
        req_valid_i = '0;
        #1 model_eval();
        if (pushes !== 3) begin n_fail++; $display("FAIL single_pushes got=%0d want=3", pushes); end
        n_checks++;
        if (busy_cycles !== 2) begin n_fail++; $display("FAIL single_busy_cycles got=%0d want=2", busy_cycles); end
        n_checks++;
        if (grant_idx_o !== 2'd3) begin n_fail++; $display("FAIL single_rr_ptr got=%0d want=3", grant_idx_o); end
        n_checks++;
        tick();
        $display("test_single done: pushes=%0d busy_cycles=%0d", pushes, busy_cycles);
    endtask

    task automatic test_fairness();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            req_valid_i = 4'hF;
            req_last_i  = 4'hF;
            #1 model_eval();
            if (grant_idx_o !== IW'(i % N)) begin n_fail++; $display("FAIL fair_grant cyc=%0d got=%0d want=%0d", i, grant_idx_o, i % N); end
            n_checks++;
            if (fifo_push_o !== 1'b1 || req_ready_o !== exp_ready) begin
                n_fail++; $display("FAIL fair_push cyc=%0d got=%b/%b want=1/%b", i, fifo_push_o, req_ready_o, exp_ready);
            end
            n_checks++;
            tick();
        end
        $display("test_fairness done");
    endtask

    task automatic test_burst_cap();
        int want;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            req_valid_i = 4'b0110;
            req_last_i  = 4'b0000;
            want = (i < 4) ? 1 : (i < 8) ? 2 : 1;
            #1 model_eval();
            if (grant_idx_o !== IW'(want) || fifo_push_o !== 1'b1) begin
                n_fail++; $display("FAIL cap_grant cyc=%0d got=%0d/%b want=%0d/1", i, grant_idx_o, fifo_push_o, want);
            end
            n_checks++;
            tick();
        end
        $display("test_burst_cap done");
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            req_valid_i = 4'b0001;
            req_last_i  = 4'b0000;
            fifo_full_i = (i >= 2 && i <= 4);
            #1 model_eval();
            if (fifo_push_o !== exp_push || req_ready_o !== exp_ready) begin
                n_fail++; $display("FAIL bp_push cyc=%0d got=%b/%b want=%b/%b", i, fifo_push_o, req_ready_o, exp_push, exp_ready);
            end
            n_checks++;
            if (i >= 1 && busy_o !== 1'b1) begin n_fail++; $display("FAIL bp_busy cyc=%0d got=%b want=1", i, busy_o); end
            n_checks++;
            tick();
        end
        // Four beats total reach the cap, so the burst must have ended here.
        fifo_full_i = 1'b0;
        req_valid_i = '0;
        #1 model_eval();
        if (busy_o !== 1'b0 || grant_idx_o !== 2'd1) begin
            n_fail++; $display("FAIL bp_end got busy=%b grant=%0d want busy=0 grant=1", busy_o, grant_idx_o);
        end
        n_checks++;
        tick();
        $display("test_backpressure done");
    endtask

    task automatic test_flush();
        apply_reset();
        req_valid_i = 4'b0010; req_last_i = 4'b0010;   // single beat, rr -> 2
        #1 model_eval();
        tick();
        for (int i = 0; i < 2; i++) begin
            req_valid_i = 4'b1000; req_last_i = 4'b0000;
            flush_i     = (i == 1);
            #1 model_eval();
            if (fifo_push_o !== exp_push || grant_idx_o !== 2'd3) begin
                n_fail++; $display("FAIL flush_beat cyc=%0d got=%b/%0d want=%b/3", i, fifo_push_o, grant_idx_o, exp_push);
            end
            n_checks++;
            tick();
        end
        flush_i = 1'b0; req_valid_i = '0;
        #1 model_eval();
        if (busy_o !== 1'b0 || grant_idx_o !== 2'd0) begin
            n_fail++; $display("FAIL flush_after got busy=%b grant=%0d want busy=0 grant=0", busy_o, grant_idx_o);
        end
        n_checks++;
        tick();
        $display("test_flush done");
    endtask

    task automatic test_throttle();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            req_valid_i     = 4'b0001;
            req_last_i      = (i == 4) ? 4'b0001 : 4'b0000;
            fifo_alm_full_i = (i != 2);   // low only where the burst may start
            #1 model_eval();
            if (fifo_push_o !== exp_push || req_ready_o !== exp_ready || busy_o !== exp_busy) begin
                n_fail++; $display("FAIL throttle cyc=%0d got=%b/%b/%b want=%b/%b/%b",
                                   i, fifo_push_o, req_ready_o, busy_o, exp_push, exp_ready, exp_busy);
            end
            n_checks++;
            tick();
        end
        fifo_alm_full_i = 1'b0;
        $display("test_throttle done");
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            rst_i           = ($urandom_range(0, 63) == 0);
            flush_i         = ($urandom_range(0, 15) == 0);
            fifo_full_i     = ($urandom_range(0, 5) == 0);
            fifo_alm_full_i = ($urandom_range(0, 3) == 0);
            req_valid_i     = N'($urandom);
            for (int k = 0; k < N; k++) req_last_i[k] = ($urandom_range(0, 2) == 0);
            req_data_i      = {$urandom, $urandom, $urandom, $urandom};
            #1 model_eval();
            if (fifo_push_o !== exp_push) begin n_fail++; $display("FAIL rnd_push cyc=%0d got=%b want=%b", i, fifo_push_o, exp_push); end
            n_checks++;
            if (req_ready_o !== exp_ready) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", i, req_ready_o, exp_ready); end
            n_checks++;
            if (fifo_data_o !== exp_data) begin n_fail++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", i, fifo_data_o, exp_data); end
            n_checks++;
            if (grant_idx_o !== IW'(exp_win)) begin n_fail++; $display("FAIL rnd_grant cyc=%0d got=%0d want=%0d", i, grant_idx_o, exp_win); end
            n_checks++;
            if (busy_o !== exp_busy) begin n_fail++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", i, busy_o, exp_busy); end
            n_checks++;
            tick();
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_burst_cap();
        test_backpressure();
        test_flush();
        test_throttle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
